// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer; returns each retiring entry's
// superseded physical reg (old_rd) to the free pool.
module reorder_buffer #(
    parameter int DEPTH      = 16,
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5,
    parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_rd,
    input  logic [PREG_WIDTH-1:0] alloc_rrd,
    input  logic [PREG_WIDTH-1:0] alloc_old_rd,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  cmpl_valid,
    input  logic [TAG_WIDTH-1:0]  cmpl_tag,
    output logic                  commit_valid,
    output logic [AREG_WIDTH-1:0] commit_rd,
    output logic [PREG_WIDTH-1:0] commit_rrd,
    output logic                  push_free_reg,
    output logic [PREG_WIDTH-1:0] freed_reg,
    output logic                  empty,
    output logic                  full
);
    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      done;
    logic [DEPTH-1:0]      reg_write;
    logic [AREG_WIDTH-1:0] rd_mem     [DEPTH];
    logic [PREG_WIDTH-1:0] rrd_mem    [DEPTH];
    logic [PREG_WIDTH-1:0] old_rd_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  head;
    logic [TAG_WIDTH-1:0]  tail;
    logic [TAG_WIDTH:0]    count;
    logic                  alloc_fire;

    assign full          = count == (TAG_WIDTH+1)'(DEPTH);
    assign empty         = count == '0;
    assign alloc_ready   = !full;
    assign alloc_tag     = tail;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign commit_valid  = valid[head] && done[head];
    assign commit_rd     = commit_valid ? rd_mem[head] : '0;
    assign commit_rrd    = commit_valid ? rrd_mem[head] : '0;
    assign freed_reg     = commit_valid ? old_rd_mem[head] : '0;
    assign push_free_reg = commit_valid && reg_write[head];

    // Later writes win: a same-edge alloc overrides a completion aimed at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cmpl_valid && valid[cmpl_tag])
                done[cmpl_tag] <= 1'b1;
            if (commit_valid) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
                head        <= head + TAG_WIDTH'(1);
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + TAG_WIDTH'(1);
            end
            count <= count + (TAG_WIDTH+1)'(alloc_fire) - (TAG_WIDTH+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            reg_write[tail]  <= alloc_reg_write && (alloc_rd != '0);
            rd_mem[tail]     <= alloc_rd;
            rrd_mem[tail]    <= alloc_rrd;
            old_rd_mem[tail] <= alloc_old_rd;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus checked against a queue-based
// model of in-order retirement.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int PW    = 6;
    localparam int AW    = 5;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_reg_write = 1'b0;
    logic [AW-1:0] alloc_rd = '0;
    logic [PW-1:0] alloc_rrd = '0;
    logic [PW-1:0] alloc_old_rd = '0;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          cmpl_valid = 1'b0;
    logic [TW-1:0] cmpl_tag = '0;
    logic          commit_valid;
    logic [AW-1:0] commit_rd;
    logic [PW-1:0] commit_rrd;
    logic          push_free_reg;
    logic [PW-1:0] freed_reg;
    logic          empty;
    logic          full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int tag;
        int rd;
        int rrd;
        int old_rd;
        bit rw;
        bit done;
    } ent_t;

    ent_t q[$];
    int   next_tag = 0;

    reorder_buffer #(.DEPTH(DEPTH), .PREG_WIDTH(PW), .AREG_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
        .alloc_rd(alloc_rd), .alloc_rrd(alloc_rrd), .alloc_old_rd(alloc_old_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rrd(commit_rrd),
        .push_free_reg(push_free_reg), .freed_reg(freed_reg),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic check_all();
        bit cv;
        cv = q.size() > 0 && q[0].done;
        chk("alloc_ready", int'(alloc_ready), int'(q.size() < DEPTH));
        chk("alloc_tag", int'(alloc_tag), next_tag);
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("commit_valid", int'(commit_valid), int'(cv));
        chk("commit_rd", int'(commit_rd), cv ? q[0].rd : 0);
        chk("commit_rrd", int'(commit_rrd), cv ? q[0].rrd : 0);
        chk("push_free_reg", int'(push_free_reg), int'(cv && q[0].rw));
        chk("freed_reg", int'(freed_reg), cv ? q[0].old_rd : 0);
    endtask

    task automatic tick();
        bit cv, rdy;
        ent_t e;
        cv  = q.size() > 0 && q[0].done;
        rdy = q.size() < DEPTH;
        @(posedge clk);
        if (rst_n) begin
            if (cmpl_valid)
                foreach (q[i]) if (q[i].tag == int'(cmpl_tag)) q[i].done = 1'b1;
            if (cv) void'(q.pop_front());
            if (alloc_valid && rdy) begin
                e.tag = next_tag; e.rd = int'(alloc_rd); e.rrd = int'(alloc_rrd);
                e.old_rd = int'(alloc_old_rd);
                e.rw = alloc_reg_write && alloc_rd != 0; e.done = 1'b0;
                q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit av, input bit rw, input int rd, input int rrd, input int old,
                       input bit cv, input int ctag);
        alloc_valid = av; alloc_reg_write = rw;
        alloc_rd = AW'(rd); alloc_rrd = PW'(rrd); alloc_old_rd = PW'(old);
        cmpl_valid = cv; cmpl_tag = TW'(ctag);
        check_all();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete(); next_tag = 0;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        // reset then idle
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_tag0", int'(alloc_tag), 0);
        // single alloc, complete, commit
        cyc(1, 1, 3, 32, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("single_commit_valid", int'(commit_valid), 1);
        chk("single_freed", int'(freed_reg), 3);
        chk("single_rrd", int'(commit_rrd), 32);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("single_empty", int'(empty), 1);
        // out-of-order completion, in-order commit
        do_reset();
        cyc(1, 1, 1, 40, 10, 0, 0);
        cyc(1, 1, 2, 41, 11, 0, 0);
        cyc(1, 1, 4, 42, 12, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("ooo_no_early_commit", int'(commit_valid), 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("ooo_freed0", int'(freed_reg), 10);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ooo_freed1", int'(freed_reg), 11);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ooo_freed2", int'(freed_reg), 12);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // x0 destination and non-writing instruction never free a reg
        cyc(1, 1, 0, 20, 21, 0, 0);
        cyc(1, 0, 7, 22, 23, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 1, 4);
        chk("x0_commit", int'(commit_valid), 1);
        chk("x0_nopush", int'(push_free_reg), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("nowrite_nopush", int'(push_free_reg), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // fill, reject when full, drain one, wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, i + 1, i + 8, i + 30, 0, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_not_ready", int'(alloc_ready), 0);
        cyc(1, 1, 9, 9, 9, 1, 0);
        chk("full_tail_held", int'(alloc_tag), 0);
        chk("full_still_full", int'(full), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain_not_full", int'(full), 0);
        chk("wrap_tag", int'(alloc_tag), 0);
        for (int i = 0; i < 20; i++) begin
            t0 = q.size() > 0 ? q[0].tag : 0;
            cyc(1, 1, i % 32, i + 1, i + 2, q.size() > 0, t0);
        end
        // async reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, i + 1, i + 40, i + 50, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("pre_reset_commit", int'(commit_valid), 1);
        #2 rst_n = 1'b0;
        q.delete(); next_tag = 0;
        #1 check_all();
        chk("async_no_push", int'(push_free_reg), 0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            t0 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                                             : int'($urandom_range(0, DEPTH - 1));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                $urandom_range(0, 2) != 0, t0);
        end
        check_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
